// File: rtl/clk_pkg.sv
// Purpose : shared types and helpers for the post-PLL clock-enable generator.
// Contents: FSM state enum, lock-counter width helper, effective-divisor helper.
package clk_pkg;

    // Lock qualification / release sequencing states
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILISE = 2'd1,
        ST_RUN       = 2'd2
    } clk_state_e;

    // Widest divisor the helper below handles
    localparam int unsigned MAX_DIV_W = 32;

    // Stability counter width: $clog2(LOCK_STABLE), never below one bit
    function automatic int unsigned lock_cnt_w(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

    // A programmed divisor of 0 behaves as divide-by-1
    function automatic logic [MAX_DIV_W-1:0] eff_div(input logic [MAX_DIV_W-1:0] d);
        return (d == '0) ? MAX_DIV_W'(1) : d;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// Purpose : one divider channel: down-counter, enable strobe, ~50% phase flag,
//           shadow divisor adopted at the period boundary.
// Ports   : clk_i/rst_i      clock, async active-high reset
//           run_q_i/run_d_i  FSM currently in RUN / in RUN next cycle
//           sync_i           realign pulse (acted on only while in RUN)
//           load_i, div_i    shadow divisor capture
//           en_o, phase_o    registered strobe and phase flag
module clk_div_chan
    import clk_pkg::*;
#(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DIV_RESET = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_q_i,
    input  logic             run_d_i,
    input  logic             sync_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             en_o,
    output logic             phase_o
);

    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] n_d;
    logic             en_q, phase_q;

    // Next counter/divisor; adoption happens only at a reload, a sync or outside RUN
    always_comb begin
        shadow_d = load_i ? div_i : shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        if (!run_q_i) begin
            active_d = shadow_d;
            if (run_d_i) begin
                cnt_d = DIV_W'(eff_div(MAX_DIV_W'(shadow_d))) - DIV_W'(1);
            end
        end else if (run_d_i) begin
            if (sync_i || (cnt_q == '0)) begin
                active_d = shadow_d;
                cnt_d    = DIV_W'(eff_div(MAX_DIV_W'(shadow_d))) - DIV_W'(1);
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
        n_d = DIV_W'(eff_div(MAX_DIV_W'(active_d)));
    end

    // Outputs registered from the next count so they line up with cnt_q
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= DIV_W'(DIV_RESET);
            active_q <= DIV_W'(DIV_RESET);
            cnt_q    <= '0;
            en_q     <= 1'b0;
            phase_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            en_q     <= run_d_i && (cnt_d == '0);
            phase_q  <= run_d_i && (cnt_d >= (n_d >> 1));
        end
    end

    assign en_o    = en_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/clk_div_multi.sv
// Purpose : post-PLL clock-enable generator. Synchronises and qualifies PLL
//           lock, sequences a synchronous reset release and drives NUM_CH
//           programmable enable strobes with phase flags.
// Ports   : in_clk, in_rst (async, active-high), in_pll_lock (async raw lock)
//           in_div (packed divisors), in_div_load, in_sync (one-cycle pulses)
//           out_rst, out_ready, out_clk_en[NUM_CH], out_clk_phase[NUM_CH]
module clk_div_multi
    import clk_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned LOCK_STABLE = 1024,
    parameter int unsigned DIV_RESET   = 1
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_pll_lock,
    input  logic [NUM_CH*DIV_W-1:0] in_div,
    input  logic                    in_div_load,
    input  logic                    in_sync,
    output logic                    out_rst,
    output logic                    out_ready,
    output logic [NUM_CH-1:0]       out_clk_en,
    output logic [NUM_CH-1:0]       out_clk_phase
);

    localparam int unsigned LOCK_CNT_W = lock_cnt_w(LOCK_STABLE);

    clk_state_e            state_q, state_d;
    logic [LOCK_CNT_W-1:0] stab_q, stab_d;
    logic                  lk_meta_q, lk_q;
    logic                  rst_q, ready_q;
    logic                  run_q, run_d;

    // Lock synchroniser, FSM and release-sequencing registers
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
            state_q   <= ST_WAIT_LOCK;
            stab_q    <= '0;
            rst_q     <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            lk_meta_q <= in_pll_lock;
            lk_q      <= lk_meta_q;
            state_q   <= state_d;
            stab_q    <= stab_d;
            rst_q     <= !run_d;
            ready_q   <= run_d;
        end
    end

    // Next-state: lock must hold LOCK_STABLE consecutive cycles before RUN
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                stab_d = '0;
                if (lk_q) begin
                    state_d = ST_STABILISE;
                end
            end
            ST_STABILISE: begin
                if (!lk_q) begin
                    state_d = ST_WAIT_LOCK;
                    stab_d  = '0;
                end else if (stab_q == LOCK_CNT_W'(LOCK_STABLE - 1)) begin
                    state_d = ST_RUN;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + LOCK_CNT_W'(1);
                end
            end
            ST_RUN: begin
                stab_d = '0;
                if (!lk_q) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                stab_d  = '0;
            end
        endcase
    end

    assign run_q = (state_q == ST_RUN);
    assign run_d = (state_d == ST_RUN);

    // Channels see next-state RUN so their outputs drop in the same cycle as out_rst rises
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_chan #(
            .DIV_W     (DIV_W),
            .DIV_RESET (DIV_RESET)
        ) u_chan (
            .clk_i   (in_clk),
            .rst_i   (in_rst),
            .run_q_i (run_q),
            .run_d_i (run_d),
            .sync_i  (in_sync),
            .load_i  (in_div_load),
            .div_i   (in_div[k*DIV_W +: DIV_W]),
            .en_o    (out_clk_en[k]),
            .phase_o (out_clk_phase[k])
        );
    end

    assign out_rst   = rst_q;
    assign out_ready = ready_q;

endmodule
